// File: rtl/ddr_reset_seq_if.sv
// Status and control bundle between the DDR bring-up sequencer and the SoC / DDR subsystem.
interface ddr_reset_seq_if;
   logic       pll_lock;
   logic       ddr_init_done;
   logic       ddr_rst_n;
   logic       ddr_ready;
   logic       init_fail;
   logic [1:0] retry_cnt;
   logic       heart_beat_led;

   modport master (
      input  pll_lock,
      input  ddr_init_done,
      output ddr_rst_n,
      output ddr_ready,
      output init_fail,
      output retry_cnt,
      output heart_beat_led
   );

   modport slave (
      output pll_lock,
      output ddr_init_done,
      input  ddr_rst_n,
      input  ddr_ready,
      input  init_fail,
      input  retry_cnt,
      input  heart_beat_led
   );
endinterface

// File: rtl/ddr_reset_seq.sv
// DDR reset/bring-up sequencer: holds the DDR controller in reset, waits for PLL lock and
// calibration under a timeout, retries a bounded number of times and drives a heartbeat LED.
module ddr_reset_seq #(
   parameter int RST_HOLD_CYC     = 50000,
   parameter int INIT_TIMEOUT_CYC = 25000000,
   parameter int HB_HALF_CYC      = 50000000,
   parameter int MAX_RETRY        = 3
) (
   input logic             clk,
   input logic             rst,
   ddr_reset_seq_if.master bus
);
   localparam int CNT_MAX = (RST_HOLD_CYC > INIT_TIMEOUT_CYC) ? RST_HOLD_CYC : INIT_TIMEOUT_CYC;
   localparam int CW      = $clog2(CNT_MAX);
   localparam int HW      = $clog2(HB_HALF_CYC);

   localparam logic [CW-1:0] HOLD_LAST = CW'(RST_HOLD_CYC - 1);
   localparam logic [CW-1:0] WAIT_LAST = CW'(INIT_TIMEOUT_CYC - 1);
   localparam logic [HW-1:0] HB_LAST   = HW'(HB_HALF_CYC - 1);
   localparam logic [HW-1:0] FAST_LAST = HW'(HB_HALF_CYC / 8 - 1);
   localparam logic [1:0]    RETRY_LIM = 2'(MAX_RETRY);

   typedef enum logic [1:0] {ST_HOLD, ST_WAIT, ST_READY, ST_FAIL} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [HW-1:0] hb, hb_nxt, hb_last;
   logic [1:0]    retry_cnt, retry_nxt;
   logic          led, led_nxt;
   logic          rst_n_q, rst_n_nxt;
   logic          ready_q, ready_nxt;
   logic          fail_q, fail_nxt;
   logic          pl_m, pl_s, id_m, id_s;

   // Two-flop synchronisers for the asynchronous lock and calibration-done inputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         pl_m <= 1'b0;
         pl_s <= 1'b0;
         id_m <= 1'b0;
         id_s <= 1'b0;
      end else begin
         pl_m <= bus.pll_lock;
         pl_s <= pl_m;
         id_m <= bus.ddr_init_done;
         id_s <= id_m;
      end
   end

   // State register together with the counters and the registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_HOLD;
         cnt       <= '0;
         hb        <= '0;
         retry_cnt <= '0;
         led       <= 1'b1;
         rst_n_q   <= 1'b0;
         ready_q   <= 1'b0;
         fail_q    <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         hb        <= hb_nxt;
         retry_cnt <= retry_nxt;
         led       <= led_nxt;
         rst_n_q   <= rst_n_nxt;
         ready_q   <= ready_nxt;
         fail_q    <= fail_nxt;
      end
   end

   // Next-state decode; calibration done takes priority over a simultaneous timeout.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_HOLD: begin
            if (cnt == HOLD_LAST) state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            if (pl_s && id_s)           state_nxt = ST_READY;
            else if (cnt == WAIT_LAST)  state_nxt = (retry_cnt < RETRY_LIM) ? ST_HOLD : ST_FAIL;
         end
         ST_READY: begin
            if (!(pl_s && id_s)) state_nxt = ST_HOLD;
         end
         ST_FAIL: begin
            state_nxt = ST_FAIL;
         end
         default: state_nxt = ST_HOLD;
      endcase
   end

   // Counter, retry, heartbeat and output values to be registered alongside the next state.
   always_comb begin
      cnt_nxt   = '0;
      hb_nxt    = '0;
      hb_last   = HB_LAST;
      led_nxt   = 1'b1;
      retry_nxt = retry_cnt;

      // Phase counter runs within HOLD/WAIT and restarts on every state change.
      if (state_nxt == state && state != ST_FAIL) cnt_nxt = cnt + 1'b1;

      if (state == ST_WAIT && state_nxt == ST_HOLD)  retry_nxt = retry_cnt + 1'b1;
      if (state == ST_READY && state_nxt == ST_HOLD) retry_nxt = '0;

      // LED blinks only in READY (slow) and FAIL (fast); it enters either state unchanged.
      if (state_nxt == ST_READY || state_nxt == ST_FAIL) begin
         led_nxt = led;
         if (state_nxt == state) begin
            hb_last = (state == ST_READY) ? HB_LAST : FAST_LAST;
            if (hb == hb_last) begin
               hb_nxt  = '0;
               led_nxt = ~led;
            end else begin
               hb_nxt = hb + 1'b1;
            end
         end
      end

      rst_n_nxt = (state_nxt == ST_WAIT) || (state_nxt == ST_READY);
      ready_nxt = (state_nxt == ST_READY);
      fail_nxt  = (state_nxt == ST_FAIL);
   end

   assign bus.ddr_rst_n      = rst_n_q;
   assign bus.ddr_ready      = ready_q;
   assign bus.init_fail      = fail_q;
   assign bus.retry_cnt      = retry_cnt;
   assign bus.heart_beat_led = led;
endmodule

// File: tb/tb_ddr_reset_seq.sv
// Testbench for ddr_reset_seq with short timing parameters.
module tb_ddr_reset_seq;
   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   ddr_reset_seq_if bus ();

   ddr_reset_seq #(
      .RST_HOLD_CYC     (16),
      .INIT_TIMEOUT_CYC (64),
      .HB_HALF_CYC      (8),
      .MAX_RETRY        (2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected output vector layout: {ddr_rst_n, ddr_ready, init_fail, retry_cnt[1:0], heart_beat_led}
   typedef struct {
      logic       rst;
      logic       pll;
      logic       idn;
      int         cyc;
      logic [5:0] exp;
      string      name;
   } vec_t;

   vec_t vecs [10];

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [5:0] exp);
      logic [5:0] act;
      act = {bus.ddr_rst_n, bus.ddr_ready, bus.init_fail, bus.retry_cnt, bus.heart_beat_led};
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b (rst_n,ready,fail,retry,led)", nm, act, exp);
      end
   endtask

   task automatic do_reset(input logic pll, input logic idn);
      rst = 1'b1;
      bus.pll_lock = pll;
      bus.ddr_init_done = idn;
      step(2);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      bus.pll_lock = 1'b0;
      bus.ddr_init_done = 1'b0;

      // Nominal bring-up: hold 16, init_done 10 cycles into WAIT, ready 3 cycles later, LED every 8.
      vecs[0] = '{1'b1, 1'b1, 1'b0, 2,  6'b0_0_0_00_1, "reset_values"};
      vecs[1] = '{1'b0, 1'b1, 1'b0, 15, 6'b0_0_0_00_1, "hold_cycle15"};
      vecs[2] = '{1'b0, 1'b1, 1'b0, 1,  6'b1_0_0_00_1, "hold_released"};
      vecs[3] = '{1'b0, 1'b1, 1'b0, 10, 6'b1_0_0_00_1, "wait_10"};
      vecs[4] = '{1'b0, 1'b1, 1'b1, 2,  6'b1_0_0_00_1, "sync_latency"};
      vecs[5] = '{1'b0, 1'b1, 1'b1, 1,  6'b1_1_0_00_1, "ready_rise"};
      vecs[6] = '{1'b0, 1'b1, 1'b1, 7,  6'b1_1_0_00_1, "led_before_1st"};
      vecs[7] = '{1'b0, 1'b1, 1'b1, 1,  6'b1_1_0_00_0, "led_toggle_1"};
      vecs[8] = '{1'b0, 1'b1, 1'b1, 7,  6'b1_1_0_00_0, "led_before_2nd"};
      vecs[9] = '{1'b0, 1'b1, 1'b1, 1,  6'b1_1_0_00_1, "led_toggle_2"};

      for (int i = 0; i < 10; i++) begin
         rst = vecs[i].rst;
         bus.pll_lock = vecs[i].pll;
         bus.ddr_init_done = vecs[i].idn;
         step(vecs[i].cyc);
         chk(vecs[i].name, vecs[i].exp);
      end

      // Timeout with retries, then FAIL with fast blink.
      do_reset(1'b1, 1'b0);
      chk("t2_reset", 6'b0_0_0_00_1);
      step(79); chk("t2_wait1_last", 6'b1_0_0_00_1);
      step(1);  chk("t2_retry1",     6'b0_0_0_01_1);
      step(15); chk("t2_hold2_last", 6'b0_0_0_01_1);
      step(1);  chk("t2_wait2",      6'b1_0_0_01_1);
      step(63); chk("t2_wait2_last", 6'b1_0_0_01_1);
      step(1);  chk("t2_retry2",     6'b0_0_0_10_1);
      step(16); chk("t2_wait3",      6'b1_0_0_10_1);
      step(63); chk("t2_wait3_last", 6'b1_0_0_10_1);
      step(1);  chk("t2_fail",       6'b0_0_1_10_1);
      step(1);  chk("t2_blink0",     6'b0_0_1_10_0);
      step(1);  chk("t2_blink1",     6'b0_0_1_10_1);
      bus.ddr_init_done = 1'b1;
      step(20); chk("t2_fail_sticky", 6'b0_0_1_10_1);

      // Reset while in FAIL, then a clean bring-up with both inputs already high.
      rst = 1'b1;
      step(1);  chk("t6_rst_in_fail", 6'b0_0_0_00_1);
      rst = 1'b0;
      step(15); chk("t6_hold_last",   6'b0_0_0_00_1);
      step(1);  chk("t6_wait",        6'b1_0_0_00_1);
      step(1);  chk("t6_ready",       6'b1_1_0_00_1);

      // Reset in the middle of WAIT_INIT.
      do_reset(1'b1, 1'b0);
      step(36); chk("t6_mid_wait",    6'b1_0_0_00_1);
      rst = 1'b1;
      step(1);  chk("t6_rst_in_wait", 6'b0_0_0_00_1);
      rst = 1'b0;
      step(16); chk("t6_after_rst",   6'b1_0_0_00_1);

      // Late success during the second WAIT_INIT, then a one-cycle lock loss.
      do_reset(1'b1, 1'b0);
      step(80); chk("t3_retry1",      6'b0_0_0_01_1);
      step(26);
      bus.ddr_init_done = 1'b1;
      step(2);  chk("t3_not_yet",     6'b1_0_0_01_1);
      step(1);  chk("t3_ready",       6'b1_1_0_01_1);
      bus.pll_lock = 1'b0;
      step(1);
      bus.pll_lock = 1'b1;
      step(1);  chk("t5_still_ready", 6'b1_1_0_01_1);
      step(1);  chk("t5_lock_lost",   6'b0_0_0_00_1);
      step(15); chk("t5_hold_last",   6'b0_0_0_00_1);
      step(1);  chk("t5_rewait",      6'b1_0_0_00_1);
      step(1);  chk("t5_reready",     6'b1_1_0_00_1);

      // Done first seen in the final timeout cycle: READY wins, no retry.
      do_reset(1'b1, 1'b0);
      step(77);
      bus.ddr_init_done = 1'b1;
      step(2);  chk("t4_edge_cycle",  6'b1_0_0_00_1);
      step(1);  chk("t4_ready",       6'b1_1_0_00_1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
